// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - parametrised single-clock FIFO with occupancy flags
//
// Purpose:
//   Single-clock FIFO for producer/consumer stages that need occupancy
//   information. Supports any DEPTH >= 2 (not only powers of two), a
//   registered or first-word-fall-through read port, an occupancy count,
//   programmable almost-full/almost-empty thresholds, a synchronous flush
//   and sticky overflow/underflow error flags.
//
// Parameters:
//   DEPTH       number of entries (>= 2, any integer)
//   DATA_WIDTH  entry width in bits
//   FWFT        0 = registered read (1-cycle latency), 1 = first-word-fall-through
//   AF_THRESH   almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH   almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports:
//   clk           system clock, all state on the rising edge
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush, highest priority after reset
//   wren, i_data  write request and write data
//   rden          read request (FWFT=1: pop the head)
//   o_data        read data
//   o_valid       o_data is valid
//   full, empty   count == DEPTH, count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         occupancy, $clog2(DEPTH+1) bits
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
`timescale 1ns/1ps

module sync_fifo_flags #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1,
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  output logic                  underflow
);

  // Pointer width never drops below one bit.
  localparam int PTR_W = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_LVL   = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_LVL   = CNT_W'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  rd_ok;
  logic                  wr_ok;

  // Explicit wrap so non-power-of-two depths never index past the array.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Status flags decode only from the registered count, never from pointers.
  assign empty        = (count == '0);
  assign full         = (count == CNT_FULL);
  assign almost_full  = (count >= AF_LVL);
  assign almost_empty = (count <= AE_LVL);

  // A read frees a slot in the same cycle, so a full FIFO still accepts a
  // write paired with a read. An empty FIFO cannot serve a paired read.
  assign rd_ok = rden & ~empty;
  assign wr_ok = wren & (~full | rd_ok);

  // Pointers, occupancy and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      // Flush drops any request issued in the same cycle without flagging it.
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (rd_ok) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count <= count - 1'b1;
      end
      if (wren && !wr_ok) begin
        overflow <= 1'b1;
      end
      if (rden && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  // Storage has no reset; stale contents are unreachable once pointers reset.
  always_ff @(posedge clk) begin
    if (rst_n && !clr && wr_ok) begin
      mem[wr_ptr] <= i_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue is presented directly from registered state; forced to
      // zero while empty so flush and reset also leave o_data at zero.
      assign o_data  = empty ? '0 : mem[rd_ptr];
      assign o_valid = ~empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] rd_data_q;
      logic                  rd_valid_q;

      // o_valid pulses for the single cycle after an accepted read; o_data
      // keeps the last word read until the next accepted read.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else if (clr) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_valid_q <= rd_ok;
          if (rd_ok) begin
            rd_data_q <= mem[rd_ptr];
          end
        end
      end

      assign o_data  = rd_data_q;
      assign o_valid = rd_valid_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - scoreboard bench for sync_fifo_flags
`timescale 1ns/1ps

module tb_sync_fifo_flags;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       clr    = 1'b0;
  logic       wren   = 1'b0;
  logic       rden   = 1'b0;
  logic [7:0] i_data = 8'h00;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  task automatic check_val(input string name, input int inst,
                           input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h expected=%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input int inst,
                           input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0b expected=%0b at %0t", name, inst, act, exp, $time);
    end
  endtask

  // Three instances share the stimulus:
  //   0: DEPTH=8 registered read, default thresholds
  //   1: DEPTH=5 registered read, AF=3 AE=2
  //   2: DEPTH=8 FWFT, AF=8 AE=0
  for (genvar g = 0; g < 3; g++) begin : u
    localparam int D  = (g == 1) ? 5 : 8;
    localparam int F  = (g == 2) ? 1 : 0;
    localparam int AF = (g == 0) ? 7 : ((g == 1) ? 3 : 8);
    localparam int AE = (g == 0) ? 1 : ((g == 1) ? 2 : 0);
    localparam int CW = $clog2(D + 1);

    logic [7:0]    o_data;
    logic          o_valid, full, empty, af, ae, ovf, udf;
    logic [CW-1:0] cnt;

    sync_fifo_flags #(
      .DEPTH(D), .DATA_WIDTH(8), .FWFT(F), .AF_THRESH(AF), .AE_THRESH(AE)
    ) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .wren(wren), .i_data(i_data),
      .rden(rden), .o_data(o_data), .o_valid(o_valid), .full(full),
      .empty(empty), .almost_full(af), .almost_empty(ae), .count(cnt),
      .overflow(ovf), .underflow(udf)
    );

    // Reference model: contents as a queue, expected read words in sb.
    logic [7:0] q[$];
    logic [7:0] sb[$];
    bit         ovf_m = 1'b0;
    bit         udf_m = 1'b0;
    bit         ev_m  = 1'b0;
    logic [7:0] od_m  = 8'h00;
    bit         rd_m, wr_m;

    initial begin : model
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n || clr) begin
          q.delete();
          sb.delete();
          ovf_m = 1'b0;
          udf_m = 1'b0;
          ev_m  = 1'b0;
          od_m  = 8'h00;
        end else begin
          rd_m = rden && (q.size() > 0);
          wr_m = wren && ((q.size() < D) || rd_m);
          if (wren && !wr_m) ovf_m = 1'b1;
          if (rden && q.size() == 0) udf_m = 1'b1;
          ev_m = rd_m;
          if (rd_m) begin
            od_m = q.pop_front();
            if (F == 0) sb.push_back(od_m);
          end
          if (wr_m) q.push_back(i_data);
        end
      end
    end

    initial begin : flag_mon
      forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) #1;
        check_val("count", g, 32'(cnt), q.size());
        check_bit("empty", g, empty, q.size() == 0);
        check_bit("full", g, full, q.size() == D);
        check_bit("almost_full", g, af, q.size() >= AF);
        check_bit("almost_empty", g, ae, q.size() <= AE);
        check_bit("overflow", g, ovf, ovf_m);
        check_bit("underflow", g, udf, udf_m);
      end
    end

    if (F == 0) begin : reg_mon
      initial begin
        forever begin
          @(negedge clk or negedge rst_n);
          if (!rst_n) #1;
          check_bit("o_valid", g, o_valid, ev_m);
          check_val("o_data_hold", g, 32'(o_data), 32'(od_m));
          if (o_valid) begin
            if (sb.size() == 0) check_val("sb_pending", g, sb.size(), 1);
            else check_val("rd_data", g, 32'(o_data), 32'(sb.pop_front()));
          end else begin
            sb.delete();
          end
        end
      end
    end else begin : fwft_mon
      initial begin
        forever begin
          @(negedge clk or negedge rst_n);
          if (!rst_n) #1;
          check_bit("o_valid", g, o_valid, q.size() != 0);
          if (o_valid && q.size() != 0) check_val("head", g, 32'(o_data), 32'(q[0]));
        end
      end
    end
  end

  task automatic step(input logic w, input logic r, input logic c, input logic [7:0] d);
    @(negedge clk);
    #1;
    wren   = w;
    rden   = r;
    clr    = c;
    i_data = d;
  endtask

  // Reset pulse starting 3ns after a falling edge, spanning a rising edge.
  task automatic reset_pulse();
    @(negedge clk);
    #3 rst_n = 1'b0;
    #10 rst_n = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #3 rst_n = 1'b1;

    // Fill with 0x11..0x18, then paired op on full, then lone write.
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 8'h11 + 8'(i));
    step(1'b1, 1'b1, 1'b0, 8'h19);
    step(1'b1, 1'b0, 1'b0, 8'h1A);
    // Drain; the final read hits empty.
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Flush at count 5 with a write pending, then a fresh word.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 8'h40 + 8'(i));
    step(1'b1, 1'b0, 1'b1, 8'hEE);
    step(1'b1, 1'b0, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Single word into empty, pop it, then paired op on empty.
    step(1'b1, 1'b0, 1'b0, 8'hA5);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 8'h5A);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h00);

    // Streaming with two words in flight across pointer wrap.
    step(1'b1, 1'b0, 1'b0, 8'h80);
    step(1'b1, 1'b0, 1'b0, 8'h81);
    for (int i = 2; i < 22; i++) step(1'b1, 1'b1, 1'b0, 8'h80 + 8'(i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'($urandom));
    reset_pulse();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 8'hC0 + 8'(i));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'h00);

    // Randomised traffic in write-heavy, balanced and read-heavy phases.
    for (int i = 0; i < 900; i++) begin
      int ph;
      int wp;
      int rp;
      ph = (i / 100) % 3;
      wp = (ph == 0) ? 80 : ((ph == 1) ? 50 : 30);
      rp = (ph == 0) ? 30 : ((ph == 1) ? 50 : 80);
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp,
           $urandom_range(0, 59) == 0, 8'($urandom));
      if (i == 450) reset_pulse();
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
